inst_dispatch_ctrl: RTL and testbench
=====================================

# inst_dispatch_ctrl

Dispatch controller sitting between the in-order instruction queue and the out-of-order backend's per-functional-unit reservation stations. It sequences queue reads and captures each returned group of up to 4 instructions into a hold stage. It then releases them strictly in program order, only as reservation-station credits for the target functional unit allow.

## Interface
Parameters:
- funcUnitCodeSize, 3, width of functional-unit code
- numFuncUnits, 8, number of functional units / reservation stations (2**funcUnitCodeSize)
- rsDepth, 8, entries per reservation station (initial credits)
- creditWidth, 4, credit counter width (holds 0..rsDepth)

Ports (one clock; reset is synchronous and active-high):
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- queueEmpty_i  in  1  queue isEmpty
- readEnable_o  out  1  dequeue request to queue
- queueValid_i  in  1  queue outputEnable, data valid this cycle
- queueNum_i  in  2  queue numInstructionsOut; value n means n+1 instructions in slots 1..n+1
- inst1FuncUnit_i..inst4FuncUnit_i  in  3 each  functional-unit code per returned slot
- holdLoad_o  out  1  load enable for external payload hold register (same cycle as capture)
- dispatchMask_o  out  4  slot k sent to its reservation station this cycle
- dispatchFU1_o..dispatchFU4_o  out  3 each  held unit code per slot
- creditReturn_i  in  numFuncUnits  bit u: one entry freed in unit u this cycle
- flush_i  in  1  pipeline flush
- busy_o  out  1  state != IDLE
- creditErr_o  out  1  sticky: return seen with counter already at rsDepth

## Operation
- Reset: state IDLE, hold mask 0, all credits = rsDepth, all outputs 0, creditErr_o 0.
- States:
  - IDLE: readEnable_o = !queueEmpty_i && !flush_i; if asserted -> WAIT.
  - WAIT: if queueValid_i, assert holdLoad_o, capture codes and mask (slots 1..queueNum_i+1) -> HOLD; else -> IDLE.
  - HOLD: dispatch, then stay or leave per the rules below.
  - DROP: ignore queueValid_i for one cycle -> IDLE.
- Dispatch (combinational from registered hold mask and registered credits):
  - Slot k dispatches iff it is valid, every earlier valid slot dispatches this cycle, and the count of dispatching valid slots j<=k with the same code is <= credit[code].
  - The first blocked slot blocks all later slots. No reordering.
- Dispatched bits clear at the edge.
- Leaving HOLD:
  - If the final valid slots dispatch this cycle and !queueEmpty_i, assert readEnable_o in the same cycle -> WAIT.
  - Otherwise, when all slots have dispatched -> IDLE.
- Credits: next = credit - dispatched_to_u + creditReturn_i[u]. A return in the same cycle is not usable for dispatch until the next cycle. If a return would exceed rsDepth, clamp at rsDepth and set creditErr_o.
- Flush (highest priority):
  - No dispatch and no readEnable_o in the flush cycle; hold mask cleared.
  - WAIT -> DROP (discards the queue response arriving next cycle); any other state -> IDLE.
  - Credits unchanged.
- Reset mid-operation: identical to power-on reset; an in-flight queue response is ignored because state is IDLE.

## Timing
- readEnable_o at cycle t -> queueValid_i at t+1 -> capture at the t+1 edge -> earliest dispatch at t+2.
- Back-to-back groups: the last dispatch at t+2 with readEnable_o asserted at t+2 gives the next dispatch at t+4 (one group per 2 cycles at best).
- dispatchMask_o and dispatchFU*_o are combinational from registered state. Downstream samples them at the edge ending the cycle.
- Credit decrement and return take effect at the same edge.
- Zero credits for the head slot's unit: the hold stage stalls indefinitely with dispatchMask_o = 0 and busy_o = 1.

## Structure
- Shared decode package: funcUnitCodeSize, numFuncUnits, FU code constants, state encodings (IDLE/WAIT/HOLD/DROP), queueNum encoding note.
- Sub-module fu_credit_bank: numFuncUnits counters with per-unit consume count (0..4) and return bit, clamp and error flag.
- Top: FSM, hold registers, in-order prefix dispatch logic.

## Test plan
- Reset, queue non-empty, 4 slots with codes 0,1,2,3 returned -> readEnable_o at t, holdLoad_o at t+1, dispatchMask_o=1111 at t+2, credits for units 0-3 = 7.
- 4 slots all unit 2, credit[2]=2 -> mask 1100. Pulse creditReturn_i[2] twice -> next cycle 0000, then 0010, then 0001. State is IDLE after the last slot.
- Slots with codes 5,1 where credit[5]=0 and credit[1]=8 -> mask 00 (slot 2 blocked behind slot 1) until a unit-5 return, then 11.
- queueNum_i=1 (2 instructions) -> only slots 1-2 held. Final dispatch with queue non-empty -> readEnable_o the same cycle.
- flush_i during WAIT -> DROP; queueValid_i next cycle ignored, holdLoad_o=0, IDLE after; credits unchanged.
- creditReturn_i[0] while credit[0]=8 -> credit stays 8, creditErr_o=1 until reset.

Source files
------------

// File: rtl/inst_dispatch_ctrl_pkg.sv
// Shared decode definitions for the instruction dispatch controller.
package inst_dispatch_ctrl_pkg;

  // Default geometry; the top-level parameters default to these.
  localparam int unsigned FuncUnitCodeSizeDef = 3;
  localparam int unsigned NumFuncUnitsDef     = 8;
  localparam int unsigned RsDepthDef          = 8;
  localparam int unsigned CreditWidthDef      = 4;

  // Hold stage holds one queue group of up to four instructions.
  localparam int unsigned NumSlots = 4;
  // Per-unit consume count per cycle: 0..NumSlots.
  localparam int unsigned ConsumeW = 3;

  // Functional-unit codes.
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit0 = 3'd0;
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit1 = 3'd1;
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit2 = 3'd2;
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit3 = 3'd3;
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit4 = 3'd4;
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit5 = 3'd5;
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit6 = 3'd6;
  localparam logic [FuncUnitCodeSizeDef-1:0] FuUnit7 = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2,
    StDrop = 2'd3
  } disp_state_e;

  // queueNum value n means n+1 instructions, packed into slots 1..n+1
  // (mask bit 0 is slot 1).
  function automatic logic [NumSlots-1:0] num_to_mask(input logic [1:0] num);
    logic [NumSlots-1:0] m;
    unique case (num)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/inst_dispatch_ctrl_fu_credit_bank.sv
// Per-functional-unit reservation-station credit counters with
// saturating return and a sticky overflow flag.
module inst_dispatch_ctrl_fu_credit_bank
  import inst_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned numFuncUnits = NumFuncUnitsDef,
  parameter int unsigned rsDepth      = RsDepthDef,
  parameter int unsigned creditWidth  = CreditWidthDef
) (
  input  logic                                    clock_i,
  input  logic                                    reset_i,
  input  logic [numFuncUnits-1:0][ConsumeW-1:0]   consume_i,
  input  logic [numFuncUnits-1:0]                 return_i,
  output logic [numFuncUnits-1:0][creditWidth-1:0] credits_o,
  output logic                                    err_o
);

  localparam int unsigned SumW = creditWidth + 1;

  logic [numFuncUnits-1:0][creditWidth-1:0] credits_q;
  logic [numFuncUnits-1:0][SumW-1:0]        sum;
  logic [numFuncUnits-1:0]                  ovf;
  logic                                     err_q;

  // Next credit per unit; consume never exceeds the current credit, so only
  // the upper bound needs clamping.
  always_comb begin
    sum = '0;
    ovf = '0;
    for (int u = 0; u < numFuncUnits; u++) begin
      sum[u] = {1'b0, credits_q[u]} - SumW'(consume_i[u]) + SumW'(return_i[u]);
      ovf[u] = sum[u] > SumW'(rsDepth);
    end
  end

  // Credit counters and sticky error flag.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int u = 0; u < numFuncUnits; u++) begin
        credits_q[u] <= creditWidth'(rsDepth);
      end
      err_q <= 1'b0;
    end else begin
      for (int u = 0; u < numFuncUnits; u++) begin
        credits_q[u] <= ovf[u] ? creditWidth'(rsDepth) : sum[u][creditWidth-1:0];
      end
      if (|ovf) begin
        err_q <= 1'b1;
      end
    end
  end

  assign credits_o = credits_q;
  assign err_o     = err_q;

endmodule

// File: rtl/inst_dispatch_ctrl.sv
// Dispatch controller: reads groups from the in-order instruction queue into
// a hold stage and releases them in program order as reservation-station
// credits allow. dispatchMask_o bit k-1 corresponds to slot k.
module inst_dispatch_ctrl
  import inst_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned funcUnitCodeSize = FuncUnitCodeSizeDef,
  parameter int unsigned numFuncUnits     = NumFuncUnitsDef,
  parameter int unsigned rsDepth          = RsDepthDef,
  parameter int unsigned creditWidth      = CreditWidthDef
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        queueEmpty_i,
  output logic                        readEnable_o,
  input  logic                        queueValid_i,
  input  logic [1:0]                  queueNum_i,
  input  logic [funcUnitCodeSize-1:0] inst1FuncUnit_i,
  input  logic [funcUnitCodeSize-1:0] inst2FuncUnit_i,
  input  logic [funcUnitCodeSize-1:0] inst3FuncUnit_i,
  input  logic [funcUnitCodeSize-1:0] inst4FuncUnit_i,
  output logic                        holdLoad_o,
  output logic [NumSlots-1:0]         dispatchMask_o,
  output logic [funcUnitCodeSize-1:0] dispatchFU1_o,
  output logic [funcUnitCodeSize-1:0] dispatchFU2_o,
  output logic [funcUnitCodeSize-1:0] dispatchFU3_o,
  output logic [funcUnitCodeSize-1:0] dispatchFU4_o,
  input  logic [numFuncUnits-1:0]     creditReturn_i,
  input  logic                        flush_i,
  output logic                        busy_o,
  output logic                        creditErr_o
);

  disp_state_e                                  state_q;
  logic [NumSlots-1:0]                          hold_mask_q;
  logic [NumSlots-1:0][funcUnitCodeSize-1:0]    codes_q;

  logic [numFuncUnits-1:0][creditWidth-1:0]     credits;
  logic [numFuncUnits-1:0][ConsumeW-1:0]        consume;
  logic [NumSlots-1:0]                          disp_mask;
  logic [ConsumeW-1:0]                          same_cnt;
  logic                                         blocked;
  logic                                         group_done;

  // In-order prefix dispatch: a slot goes only if all earlier held slots go
  // and its unit has credit for every same-unit slot up to and including it.
  always_comb begin
    disp_mask = '0;
    blocked   = 1'b0;
    same_cnt  = '0;
    for (int k = 0; k < NumSlots; k++) begin
      same_cnt = '0;
      for (int j = 0; j <= k; j++) begin
        if (hold_mask_q[j] && (codes_q[j] == codes_q[k])) begin
          same_cnt = same_cnt + ConsumeW'(1);
        end
      end
      if (hold_mask_q[k]) begin
        if (!blocked && (creditWidth'(same_cnt) <= credits[codes_q[k]])) begin
          disp_mask[k] = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
    if ((state_q != StHold) || flush_i || reset_i) begin
      disp_mask = '0;
    end
  end

  // Per-unit count of slots dispatched this cycle.
  always_comb begin
    consume = '0;
    for (int u = 0; u < numFuncUnits; u++) begin
      for (int k = 0; k < NumSlots; k++) begin
        if (disp_mask[k] && (codes_q[k] == funcUnitCodeSize'(u))) begin
          consume[u] = consume[u] + ConsumeW'(1);
        end
      end
    end
  end

  // The whole remaining group leaves this cycle (hold mask is never empty in HOLD).
  assign group_done = (state_q == StHold) && (disp_mask == hold_mask_q) && !flush_i && !reset_i;

  assign readEnable_o = !reset_i && !flush_i && !queueEmpty_i &&
                        ((state_q == StIdle) || group_done);
  assign holdLoad_o   = !reset_i && !flush_i && (state_q == StWait) && queueValid_i;
  assign busy_o       = (state_q != StIdle);

  assign dispatchMask_o = disp_mask;
  assign dispatchFU1_o  = codes_q[0];
  assign dispatchFU2_o  = codes_q[1];
  assign dispatchFU3_o  = codes_q[2];
  assign dispatchFU4_o  = codes_q[3];

  // Sequencing FSM and hold-stage registers; flush overrides normal progress.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      hold_mask_q <= '0;
      codes_q     <= '0;
    end else if (flush_i) begin
      // A response to an already-issued read may still arrive; swallow it.
      state_q     <= (state_q == StWait) ? StDrop : StIdle;
      hold_mask_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!queueEmpty_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (queueValid_i) begin
            state_q     <= StHold;
            hold_mask_q <= num_to_mask(queueNum_i);
            codes_q[0]  <= inst1FuncUnit_i;
            codes_q[1]  <= inst2FuncUnit_i;
            codes_q[2]  <= inst3FuncUnit_i;
            codes_q[3]  <= inst4FuncUnit_i;
          end else begin
            state_q <= StIdle;
          end
        end
        StHold: begin
          hold_mask_q <= hold_mask_q & ~disp_mask;
          if (group_done) begin
            state_q <= queueEmpty_i ? StIdle : StWait;
          end
        end
        StDrop: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  inst_dispatch_ctrl_fu_credit_bank #(
    .numFuncUnits (numFuncUnits),
    .rsDepth      (rsDepth),
    .creditWidth  (creditWidth)
  ) u_credit_bank (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .consume_i (consume),
    .return_i  (creditReturn_i),
    .credits_o (credits),
    .err_o     (creditErr_o)
  );

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// Randomised scoreboard bench for inst_dispatch_ctrl against a list-based
// reference model of the hold stage and credit pool.
module tb_inst_dispatch_ctrl;

  logic       clock_i = 1'b0;
  logic       rst = 1'b1;
  logic       qe = 1'b1;
  logic       qv = 1'b0;
  logic [1:0] qnum = 2'd0;
  logic [2:0] qcode [4];
  logic [7:0] ret = '0;
  logic       flush = 1'b0;

  logic       re_o, hl_o, busy_o, err_o;
  logic [3:0] mask_o;
  logic [2:0] fu1_o, fu2_o, fu3_o, fu4_o;

  always #5 clock_i = ~clock_i;

  inst_dispatch_ctrl dut (
    .clock_i         (clock_i),
    .reset_i         (rst),
    .queueEmpty_i    (qe),
    .readEnable_o    (re_o),
    .queueValid_i    (qv),
    .queueNum_i      (qnum),
    .inst1FuncUnit_i (qcode[0]),
    .inst2FuncUnit_i (qcode[1]),
    .inst3FuncUnit_i (qcode[2]),
    .inst4FuncUnit_i (qcode[3]),
    .holdLoad_o      (hl_o),
    .dispatchMask_o  (mask_o),
    .dispatchFU1_o   (fu1_o),
    .dispatchFU2_o   (fu2_o),
    .dispatchFU3_o   (fu3_o),
    .dispatchFU4_o   (fu4_o),
    .creditReturn_i  (ret),
    .flush_i         (flush),
    .busy_o          (busy_o),
    .creditErr_o     (err_o)
  );

  typedef struct packed {
    logic            re;
    logic            hl;
    logic            busy;
    logic            err;
    logic [3:0]      mask;
    logic [3:0]      fu_chk;
    logic [3:0][2:0] fu;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: phase 0 idle, 1 waiting, 2 holding, 3 dropping.
  // The held group is code_m[head..last]; credits are plain integers.
  int ph = 0;
  int head = 0;
  int last = -1;
  int code_m[4];
  int cred[8];
  int occ[8];
  bit err_m = 1'b0;
  bit re_prev = 1'b0;

  function automatic void model_outputs(output exp_t e, output int n);
    int tmp[8];
    e = '0;
    n = 0;
    e.busy = (ph != 0);
    e.err  = err_m;
    if (ph == 2) begin
      for (int k = head; k <= last; k++) begin
        e.fu_chk[k] = 1'b1;
        e.fu[k]     = 3'(code_m[k]);
      end
    end
    if (!flush) begin
      case (ph)
        0: e.re = !qe;
        1: e.hl = qv;
        2: begin
          tmp = cred;
          for (int k = head; k <= last; k++) begin
            if (tmp[code_m[k]] > 0) begin
              tmp[code_m[k]]--;
              n++;
            end else begin
              break;
            end
          end
          for (int k = head; k < head + n; k++) e.mask[k] = 1'b1;
          if (head + n > last) e.re = !qe;
        end
        default: ;
      endcase
    end
  endfunction

  task automatic model_update(input int n);
    if (rst) begin
      ph = 0; head = 0; last = -1; err_m = 1'b0;
      for (int u = 0; u < 8; u++) begin cred[u] = 8; occ[u] = 0; end
      return;
    end
    for (int k = head; k < head + n; k++) begin
      cred[code_m[k]]--;
      occ[code_m[k]]++;
    end
    for (int u = 0; u < 8; u++) begin
      if (ret[u]) begin
        cred[u]++;
        if (occ[u] > 0) occ[u]--;
        if (cred[u] > 8) begin cred[u] = 8; err_m = 1'b1; end
      end
    end
    if (flush) begin
      ph = (ph == 1) ? 3 : 0;
      last = head - 1;
    end else begin
      case (ph)
        0: if (!qe) ph = 1;
        1: begin
          if (qv) begin
            for (int k = 0; k < 4; k++) code_m[k] = int'(qcode[k]);
            head = 0; last = int'(qnum); ph = 2;
          end else begin
            ph = 0;
          end
        end
        2: begin
          head = head + n;
          if (head > last) ph = qe ? 0 : 1;
        end
        default: ph = 0;
      endcase
    end
  endtask

  // One clock: predict, queue the prediction, advance the model past the edge.
  task automatic cycle();
    exp_t e;
    int   n;
    model_outputs(e, n);
    if (!rst) exp_q.push_back(e);
    @(posedge clock_i);
    #1;
    model_update(n);
    re_prev = e.re;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  exp_t            mon_e;
  logic [3:0][2:0] act_fu;

  // Monitor: compare each cycle's DUT outputs with the queued prediction.
  always @(negedge clock_i) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      act_fu = {fu4_o, fu3_o, fu2_o, fu1_o};
      chk("readEnable", 32'(re_o), 32'(mon_e.re));
      chk("holdLoad", 32'(hl_o), 32'(mon_e.hl));
      chk("busy", 32'(busy_o), 32'(mon_e.busy));
      chk("creditErr", 32'(err_o), 32'(mon_e.err));
      chk("dispatchMask", 32'(mask_o), 32'(mon_e.mask));
      for (int k = 0; k < 4; k++) begin
        if (mon_e.fu_chk[k]) chk("dispatchFU", 32'(act_fu[k]), 32'(mon_e.fu[k]));
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) qcode[k] = 3'd0;
    // Power-on reset.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    // Group with codes 0,1,2,3: read, capture, full dispatch.
    qe = 1'b0; qv = 1'b0;
    cycle();
    qe = 1'b1; qv = 1'b1; qnum = 2'd3;
    for (int k = 0; k < 4; k++) qcode[k] = 3'(k);
    cycle();
    qv = 1'b0;
    cycle();
    cycle();
    // Flush while waiting: the response is dropped.
    qe = 1'b0;
    cycle();
    flush = 1'b1; qv = 1'b1; qe = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    qv = 1'b0;
    cycle();
    // Return into unit 0 twice; the second overflows and sets the sticky flag.
    ret = 8'h01;
    cycle();
    cycle();
    ret = 8'h00;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();

    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 599) == 0);
      flush = !rst && ($urandom_range(0, 24) == 0);
      qe    = ($urandom_range(0, 3) == 0);
      qv    = re_prev ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      qnum  = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        qcode[k] = ((c % 1000) < 500) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      end
      ret = '0;
      if (!rst && !flush) begin
        for (int u = 0; u < 8; u++) begin
          if (occ[u] > 0) begin
            if ((c >= 2000 && c < 2500) ? ($urandom_range(0, 15) == 0)
                                        : ($urandom_range(0, 3) == 0)) ret[u] = 1'b1;
          end
        end
      end
      cycle();
    end
    rst = 1'b0; flush = 1'b0; ret = '0; qv = 1'b0; qe = 1'b1;
    repeat (2) @(negedge clock_i);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
